// File: rtl/mem_arbiter.sv
// Round-robin arbiter for iCache/dCache line fills and dCache writebacks onto a
// single-ported, fixed-latency, internally modelled main memory.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int MEM_LATENCY = 5,
  parameter int MEM_LINES   = 256,
  parameter int LINE_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic [LINE_WIDTH-1:0] ic_fill_data,
  output logic                  ic_rdy,
  input  logic                  dc_req,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic                  dc_wb_valid,
  input  logic [ADDR_WIDTH-1:0] dc_wb_addr,
  input  logic [LINE_WIDTH-1:0] dc_wb_data,
  output logic [LINE_WIDTH-1:0] dc_fill_data,
  output logic                  dc_rdy,
  output logic                  busy
);

  localparam int IDX_W = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_last_dc;
  logic                  r_sel_dc;
  logic [IDX_W-1:0]      r_fill_idx;
  logic [IDX_W-1:0]      r_wb_idx;
  logic [LINE_WIDTH-1:0] r_wb_data;
  logic [LINE_WIDTH-1:0] r_mem [MEM_LINES];

  logic w_cnt_done;
  logic w_grant;
  logic w_grant_dc;
  logic w_mem_we;
  logic w_fill_done;
  logic w_unused;

  // Only the line-index slice of each address is meaningful.
  assign w_unused   = ^{ic_addr, dc_addr, dc_wb_addr};
  assign w_cnt_done = (r_cnt == CNT_W'(MEM_LATENCY));
  assign busy       = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant     = 1'b0;
    w_grant_dc  = 1'b0;
    w_mem_we    = 1'b0;
    w_fill_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ic_req || dc_req) begin
          w_grant     = 1'b1;
          // On a tie, the port that did not win last time is served.
          w_grant_dc  = dc_req && (!ic_req || !r_last_dc);
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = (w_grant_dc && dc_wb_valid) ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        if (w_cnt_done) begin
          w_mem_we    = 1'b1;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = S_FILL;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_FILL: begin
        if (w_cnt_done) begin
          w_fill_done = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_dc    <= 1'b0;
      r_sel_dc     <= 1'b0;
      r_fill_idx   <= '0;
      r_wb_idx     <= '0;
      r_wb_data    <= '0;
      ic_rdy       <= 1'b0;
      dc_rdy       <= 1'b0;
      ic_fill_data <= '0;
      dc_fill_data <= '0;
    end else begin
      if (w_grant) begin
        r_sel_dc   <= w_grant_dc;
        r_last_dc  <= w_grant_dc;
        r_fill_idx <= w_grant_dc ? dc_addr[4 +: IDX_W] : ic_addr[4 +: IDX_W];
        if (w_grant_dc) begin
          r_wb_idx  <= dc_wb_addr[4 +: IDX_W];
          r_wb_data <= dc_wb_data;
        end
      end
      ic_rdy <= w_fill_done && !r_sel_dc;
      dc_rdy <= w_fill_done && r_sel_dc;
      if (w_fill_done) begin
        if (r_sel_dc) begin
          dc_fill_data <= r_mem[r_fill_idx];
        end else begin
          ic_fill_data <= r_mem[r_fill_idx];
        end
      end
    end
  end

  // Memory contents survive reset; only the writeback commit edge touches them.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_wb_idx] <= r_wb_data;
    end
  end

endmodule
